// File: rtl/fmap_loader.sv
// Stream-to-frame loader: packs W-pixel words into IC binary maps, holds the
// frame for the conv/pool stage and releases it on that stage's done level.
//
// state   | meaning
// FILL    | accepting stream words into img_out
// HOLD    | complete frame held, data_in_ready high
// RELEASE | one-cycle handback, counters cleared
module fmap_loader #(
    parameter int IC       = 4,
    parameter int IMG_SIZE = 30,
    parameter int W        = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [W-1:0]                   s_data,
    input  logic                           s_last,
    output logic [IMG_SIZE*IMG_SIZE-1:0]   img_out [0:IC-1],
    output logic                           data_in_ready,
    input  logic                           data_out_ready,
    output logic                           frame_err
);

    localparam int NPIX  = IMG_SIZE * IMG_SIZE;
    localparam int POS_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CH_W  = (IC > 1) ? $clog2(IC) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NPIX - W);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(IC - 1);

    generate
        if (NPIX % W != 0) begin : g_bad_w
            $error("fmap_loader: IMG_SIZE*IMG_SIZE must be a multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {FILL, HOLD, RELEASE} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch;
    logic [POS_W-1:0]  pos;
    logic              run_q;
    logic              beat, final_beat, err_nxt, cnt_clr;

    // run_q keeps s_ready low during reset and releases it on the first clock
    assign s_ready       = (state == FILL) && run_q;
    assign data_in_ready = (state == HOLD);
    assign beat          = s_valid && s_ready;
    assign final_beat    = beat && (pos == POS_MAX) && (ch == CH_MAX);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            FILL: begin
                if (beat) begin
                    if (final_beat && s_last) begin
                        state_nxt = HOLD;
                        cnt_clr   = 1'b1;
                    end else if (final_beat || s_last) begin
                        err_nxt = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (data_out_ready) state_nxt = RELEASE;
            end
            RELEASE: begin
                state_nxt = FILL;
                cnt_clr   = 1'b1;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            run_q     <= 1'b0;
            frame_err <= 1'b0;
            ch        <= '0;
            pos       <= '0;
        end else begin
            state     <= state_nxt;
            run_q     <= 1'b1;
            frame_err <= err_nxt;
            if (cnt_clr) begin
                ch  <= '0;
                pos <= '0;
            end else if (beat) begin
                if (pos == POS_MAX) begin
                    pos <= '0;
                    ch  <= ch + CH_W'(1);
                end else begin
                    pos <= pos + POS_W'(W);
                end
            end
        end
    end

    // Pixels from aborted frames stay until the next frame overwrites them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < IC; c++) img_out[c] <= '0;
        end else if (beat) begin
            img_out[ch][pos +: W] <= s_data;
        end
    end

endmodule
